// File: rtl/chip8_ram_arbiter.sv
// Three-port arbiter for the shared single-port Chip-8 RAM (CPU, blitter, loader/OSD).
// One access per clock, read data tagged back to the issuing port, optional locked bursts.
module chip8_ram_arbiter #(
    parameter int ADDR_W     = 12,
    parameter int RD_LATENCY = 1,
    parameter int LOCK_MAX   = 64,
    parameter int FIXED_PRIO = 0
) (
    input  logic                  clk,
    input  logic                  res_n,
    input  logic [2:0]            req,
    input  logic [2:0]            wr,
    input  logic [2:0]            lock,
    input  logic [3*ADDR_W-1:0]   addr,
    input  logic [23:0]           wdata,
    output logic [2:0]            gnt,
    output logic [2:0]            rvalid,
    output logic [7:0]            rdata,
    output logic                  lock_err,
    output logic                  ram_en,
    output logic                  ram_wr,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic [7:0]            ram_in,
    input  logic [7:0]            ram_out
);

    localparam int DEPTH = RD_LATENCY + 1;
    localparam int CNT_W = $clog2(LOCK_MAX + 1);

    logic [1:0]       ptr;
    logic             lock_held;
    logic [1:0]       lock_owner;
    logic [CNT_W-1:0] lock_cnt;

    logic             tag_vld  [DEPTH];
    logic [1:0]       tag_port [DEPTH];

    logic             acc;
    logic [1:0]       acc_idx;
    logic [2:0]       cand;
    logic             found;

    // A held lock masks every other requester; otherwise fixed priority or
    // round-robin starting just after the last accepted port.
    always_comb begin
        gnt   = 3'b000;
        cand  = 3'd0;
        found = 1'b0;
        if (!res_n) begin
            gnt = 3'b000;
        end else if (lock_held) begin
            gnt = req & (3'b001 << lock_owner);
        end else if (FIXED_PRIO != 0) begin
            if (req[0])      gnt = 3'b001;
            else if (req[1]) gnt = 3'b010;
            else if (req[2]) gnt = 3'b100;
        end else begin
            for (int i = 1; i <= 3; i++) begin
                cand = 3'(ptr) + 3'(i);
                if (cand >= 3'd3) cand = cand - 3'd3;
                if (cand >= 3'd3) cand = cand - 3'd3;
                if (!found && req[cand[1:0]]) begin
                    gnt[cand[1:0]] = 1'b1;
                    found          = 1'b1;
                end
            end
        end
    end

    assign acc     = |gnt;
    assign acc_idx = gnt[1] ? 2'd1 : (gnt[2] ? 2'd2 : 2'd0);

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            ram_en   <= 1'b0;
            ram_wr   <= 1'b0;
            ram_addr <= '0;
            ram_in   <= '0;
            ptr      <= 2'd2;
        end else begin
            ram_en <= acc;
            ram_wr <= acc & wr[acc_idx];
            if (acc) begin
                ram_addr <= addr[acc_idx*ADDR_W +: ADDR_W];
                ram_in   <= wdata[acc_idx*8 +: 8];
                ptr      <= acc_idx;
            end
        end
    end

    // Read tags ride alongside the RAM pipeline so data returns to the right port.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                tag_vld[i]  <= 1'b0;
                tag_port[i] <= 2'd0;
            end
        end else begin
            tag_vld[0]  <= acc & ~wr[acc_idx];
            tag_port[0] <= acc_idx;
            for (int i = 1; i < DEPTH; i++) begin
                tag_vld[i]  <= tag_vld[i-1];
                tag_port[i] <= tag_port[i-1];
            end
        end
    end

    assign rvalid = tag_vld[DEPTH-1] ? (3'b001 << tag_port[DEPTH-1]) : 3'b000;
    assign rdata  = ram_out;

    // Re-locking takes precedence over a timeout landing in the same cycle.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            lock_held  <= 1'b0;
            lock_owner <= 2'd0;
            lock_cnt   <= '0;
            lock_err   <= 1'b0;
        end else if (acc && lock[acc_idx]) begin
            lock_held  <= 1'b1;
            lock_owner <= acc_idx;
            lock_cnt   <= '0;
        end else if (acc && lock_held) begin
            lock_held <= 1'b0;
            lock_cnt  <= '0;
        end else if (lock_held) begin
            if (lock_cnt == CNT_W'(LOCK_MAX - 1)) begin
                lock_held <= 1'b0;
                lock_cnt  <= '0;
                lock_err  <= 1'b1;
            end else begin
                lock_cnt <= lock_cnt + 1'b1;
            end
        end
    end

endmodule
